// File: rtl/writeback_unit_pkg.sv
// Shared types for the writeback unit: register index, result source tag and
// the {rd, data} entry that travels from a result source to the register file.
package writeback_unit_pkg;

  typedef logic [4:0] rv32_register;

  typedef enum logic {
    WB_SRC_A = 1'b0,
    WB_SRC_B = 1'b1
  } wb_src_e;

  typedef struct packed {
    rv32_register rd;
    logic [31:0]  data;
  } wb_entry_t;

  localparam int unsigned NUM_REGS = 32;

endpackage

// File: rtl/wb_hold_buffer.sv
// One-entry valid/ready holding register in front of the writeback arbiter.
// The arbiter empties it through i_drain; a drained slot can refill on the same edge.
module wb_hold_buffer
  import writeback_unit_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_valid,
  input  wb_entry_t i_entry,
  output logic      o_ready,
  input  logic      i_drain,
  output logic      o_full,
  output wb_entry_t o_entry
);

  logic      full_q, full_d;
  wb_entry_t entry_q, entry_d;
  logic      accept;

  // Ready is forced low while reset is held so nothing is accepted then.
  assign o_ready = i_rst && (!full_q || i_drain);
  assign accept  = i_valid && o_ready;

  always_comb begin
    full_d  = full_q;
    entry_d = entry_q;
    if (i_drain) begin
      full_d = 1'b0;
    end
    if (accept) begin
      full_d  = 1'b1;
      entry_d = i_entry;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
    end
  end

  assign o_full  = full_q;
  assign o_entry = entry_q;

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: two result sources arbitrated into one register-file write
// port, plus a 32-entry busy scoreboard. WB_BYPASS_EN adds write-port forwarding.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter string ARB_MODE = "round_robin"
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_issue_valid,
  input  rv32_register i_issue_rd,
  output logic         o_issue_ready,
  input  rv32_register i_rs1,
  input  rv32_register i_rs2,
  output logic         o_rs1_busy,
  output logic         o_rs2_busy,
  input  logic         i_a_valid,
  input  rv32_register i_a_rd,
  input  logic [31:0]  i_a_data,
  output logic         o_a_ready,
  input  logic         i_b_valid,
  input  rv32_register i_b_rd,
  input  logic [31:0]  i_b_data,
  output logic         o_b_ready,
  output logic         o_we,
  output rv32_register o_rd,
  output logic [31:0]  o_rd_data
`ifdef WB_BYPASS_EN
  ,
  output logic         o_fwd_rs1_valid,
  output logic [31:0]  o_fwd_rs1_data,
  output logic         o_fwd_rs2_valid,
  output logic [31:0]  o_fwd_rs2_data
`endif
);

  generate
    if (ARB_MODE != "round_robin" && ARB_MODE != "fixed") begin : g_bad_arb_mode
      $error("writeback_unit: ARB_MODE must be \"round_robin\" or \"fixed\"");
    end
  endgenerate

  localparam bit FIXED_ARB = (ARB_MODE == "fixed");

  wb_entry_t a_in, b_in, a_entry, b_entry, win_entry;
  logic      a_full, b_full;
  logic      grant_a, grant_b, contested, commit_valid;
  wb_src_e   fav_q, fav_d;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                issue_set;

  logic         we_q, we_d;
  rv32_register rd_q, rd_d;
  logic [31:0]  data_q, data_d;

  assign a_in = '{rd: i_a_rd, data: i_a_data};
  assign b_in = '{rd: i_b_rd, data: i_b_data};

  wb_hold_buffer u_hold_a (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_a_valid),
    .i_entry (a_in),
    .o_ready (o_a_ready),
    .i_drain (grant_a),
    .o_full  (a_full),
    .o_entry (a_entry)
  );

  wb_hold_buffer u_hold_b (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_b_valid),
    .i_entry (b_in),
    .o_ready (o_b_ready),
    .i_drain (grant_b),
    .o_full  (b_full),
    .o_entry (b_entry)
  );

  // fav_q names the source that wins the next contested cycle; it only moves
  // when both holds are full, so a lone source never disturbs the rotation.
  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    fav_d     = fav_q;
    contested = a_full && b_full;
    if (contested) begin
      if (FIXED_ARB || fav_q == WB_SRC_A) begin
        grant_a = 1'b1;
      end else begin
        grant_b = 1'b1;
      end
      if (!FIXED_ARB) begin
        fav_d = grant_a ? WB_SRC_B : WB_SRC_A;
      end
    end else begin
      grant_a = a_full;
      grant_b = b_full;
    end
  end

  assign commit_valid = grant_a || grant_b;
  assign win_entry    = grant_b ? b_entry : a_entry;

  // x0 results are dequeued but never reach the register file.
  always_comb begin
    we_d   = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    if (commit_valid) begin
      we_d   = (win_entry.rd != 5'd0);
      rd_d   = win_entry.rd;
      data_d = win_entry.data;
    end
  end

  assign o_issue_ready = i_rst && !busy_q[i_issue_rd];
  assign issue_set     = i_issue_valid && o_issue_ready && (i_issue_rd != 5'd0);

  // Clear follows the cycle o_we is high for rd_q; a set for the same rd is
  // impossible because that rd is still busy and issue stalls on it.
  always_comb begin
    busy_d = busy_q;
    if (we_q) begin
      busy_d[rd_q] = 1'b0;
    end
    if (issue_set) begin
      busy_d[i_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      fav_q  <= WB_SRC_A;
      busy_q <= '0;
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      fav_q  <= fav_d;
      busy_q <= busy_d;
      we_q   <= we_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  assign o_rs1_busy = busy_q[i_rs1];
  assign o_rs2_busy = busy_q[i_rs2];

  assign o_we      = we_q;
  assign o_rd      = rd_q;
  assign o_rd_data = data_q;

`ifdef WB_BYPASS_EN
  assign o_fwd_rs1_valid = we_q && (rd_q == i_rs1) && (rd_q != 5'd0);
  assign o_fwd_rs1_data  = data_q;
  assign o_fwd_rs2_valid = we_q && (rd_q == i_rs2) && (rd_q != 5'd0);
  assign o_fwd_rs2_data  = data_q;
`endif

endmodule
